multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS core. It steps the shared datapath (single memory port, ALU,
//  register file) through the IFETCH/DECODE/EXEC/MEM/WB phases, one instruction at a time.
//  It handshakes with the memory port and runs a wait-timeout watchdog.
//  It halts on syscall, illegal opcode or bus timeout, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  255  consecutive mem_ready=0 cycles tolerated in IFETCH/MEM before bus error (>=1)
//  CNT_W        32   width of retired-instruction counter
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  rst_b         in   1      asynchronous active-low reset
//  opcode        in   6      IR[31:26], valid from DECODE onward
//  func          in   6      IR[5:0], valid from DECODE onward
//  branch_taken  in   1      ALU branch-compare result, sampled in EXEC
//  mem_ready     in   1      memory port completes the current mem_req this cycle
//  mem_req       out  1      memory access request (held until mem_ready)
//  mem_we        out  1      write strobe, qualifies mem_req
//  addr_sel      out  1      0=PC, 1=ALU result drives memory address
//  ir_write      out  1      load IR from memory read data
//  pc_write      out  1      update PC
//  pc_src        out  2      0=PC+4, 1=branch target, 2=jump target
//  reg_write     out  1      register-file write enable
//  mem_to_reg    out  1      1=memory data, 0=ALU result to register file
//  halted        out  1      sticky halt indication
//  illegal_op    out  1      sticky: halted on unknown opcode
//  bus_err       out  1      sticky: halted on memory timeout
//  retired       out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_b=0, async): state=RST, wait_cnt=0, retired=0, class=NONE, all outputs 0.
//  States (3b): RST=0 IFETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6. Undefined codes go to HALT.
//  RST: all outputs 0. Goes to IFETCH on the first clock after rst_b rises.
//  IFETCH: mem_req=1, addr_sel=0, mem_we=0.
//   - If mem_ready=1: ir_write=1 and pc_write=1 (pc_src=0) in the same cycle, then go to DECODE.
//  DECODE: latch class from opcode/func. No strobes.
//   - R(op 000000, func!=001100) -> EXEC.
//   - SYSCALL(op 000000, func=001100) -> HALT.
//   - IMM(001000,001001,001100,001101,001110,001010,001111) -> EXEC.
//   - LOAD(100011,100000) -> EXEC.  STORE(101011,101000) -> EXEC.
//   - BR(000100,000101,000110,000111,000001) -> EXEC.  J(000010) and JAL(000011) -> EXEC.
//   - Any other opcode -> HALT with illegal_op=1.
//  EXEC:
//   - R/IMM -> WB.  LOAD/STORE -> MEM.
//   - BR: pc_write=branch_taken, pc_src=1. Retire, then IFETCH.
//   - J: pc_write=1, pc_src=2. Retire, then IFETCH.
//   - JAL: as J, plus reg_write=1 and mem_to_reg=0 (link value on ALU path).
//  MEM: mem_req=1, addr_sel=1, mem_we=(class==STORE).
//   - On mem_ready: LOAD -> WB. STORE -> retire, then IFETCH.
//  WB: reg_write=1, mem_to_reg=(class==LOAD). Retire, then IFETCH.
//  HALT: terminal until reset. halted=1. All strobes 0. retired frozen.
//  Outputs are Moore on state, except ir_write/pc_write in IFETCH, which are Mealy on mem_ready.
//  Latency with zero-wait memory: R/IMM 4 cycles, LOAD 5, STORE 4, BR/J/JAL 3.
//  Handshake:
//   - mem_req stays high and address/we stay stable until mem_ready=1. No request is withdrawn.
//   - mem_ready while mem_req=0 is ignored.
//  Watchdog (wait_cnt):
//   - Cleared on entering IFETCH or MEM and on each handshake.
//   - Increments each IFETCH/MEM cycle with mem_ready=0.
//   - When wait_cnt==MEM_TIMEOUT-1 and mem_ready=0 -> HALT, bus_err=1.
//   - mem_ready=1 on that same cycle wins: normal progress, no error.
//  retired increments by exactly 1 on each retire cycle. It wraps from 2^CNT_W-1 to 0.
//  Syscall and illegal instructions do not retire.
//  rst_b low in any state, mid-handshake included: immediate return to RST.
//   - mem_req drops asynchronously. Sticky flags and counter clear.
// TESTING
//  1. Reset then R-type ADD (op 0, func 100000), mem_ready=1 always:
//     IFETCH,DECODE,EXEC,WB. reg_write=1 in cycle 4 only; retired=1.
//  2. LW (op 100011) with 3-cycle data wait:
//     MEM holds mem_req=1, addr_sel=1, mem_we=0 for 4 cycles. WB has mem_to_reg=1. retired=1.
//  3. BEQ with branch_taken=0, then BEQ with branch_taken=1:
//     pc_write=0, then pc_write=1 with pc_src=1. 3 cycles each; retired=2.
//  4. Syscall (op 0, func 001100): HALT after DECODE, halted=1, retired unchanged.
//     Opcode 111111 gives HALT with illegal_op=1.
//  5. MEM_TIMEOUT=4, mem_ready=0 in IFETCH: 4th waiting cycle -> HALT, bus_err=1.
//     Repeat with mem_ready=1 on the 4th cycle: DECODE, no error.
//  6. rst_b pulsed low mid-MEM of an SW: mem_req=0 immediately; state=RST, retired=0.
//     CNT_W=2 run of 5 instructions ends with retired=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: walks IFETCH/DECODE/EXEC/MEM/WB one instruction at a time, 3-5 cycles each with zero-wait memory.
// Holds mem_req until mem_ready; a stalled access beyond MEM_TIMEOUT cycles halts with bus_err.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RST = 3'd0, S_IFETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_IMM, C_LOAD, C_STORE, C_BR, C_J, C_JAL
    } cls_t;

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d, dec_cls;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q;
    logic              ill_q, ill_d, berr_q, berr_d;
    logic              is_sys, is_ill, retire;
    logic              mem_req_q, mem_we_q, addr_sel_q, reg_write_q, mem_to_reg_q, halted_q;
    logic [1:0]        pc_src_q;

    always_comb begin
        dec_cls = C_NONE;
        is_sys  = 1'b0;
        is_ill  = 1'b0;
        case (opcode)
            6'b000000: begin
                if (func == 6'b001100) is_sys = 1'b1;
                else                   dec_cls = C_R;
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001111:             dec_cls = C_IMM;
            6'b100011, 6'b100000:                        dec_cls = C_LOAD;
            6'b101011, 6'b101000:                        dec_cls = C_STORE;
            6'b000100, 6'b000101, 6'b000110,
            6'b000111, 6'b000001:                        dec_cls = C_BR;
            6'b000010:                                   dec_cls = C_J;
            6'b000011:                                   dec_cls = C_JAL;
            default:                                     is_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = wait_q;
        ill_d   = ill_q;
        berr_d  = berr_q;
        retire  = 1'b0;
        case (state_q)
            S_RST:    state_d = S_IFETCH;
            S_IFETCH, S_MEM: begin
                // A ready on the final allowed cycle still completes normally.
                if (mem_ready) begin
                    wait_d = '0;
                    if (state_q == S_IFETCH)  state_d = S_DECODE;
                    else if (cls_q == C_LOAD) state_d = S_WB;
                    else begin
                        retire  = 1'b1;
                        state_d = S_IFETCH;
                    end
                end else if (wait_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    berr_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (is_sys) state_d = S_HALT;
                else if (is_ill) begin
                    state_d = S_HALT;
                    ill_d   = 1'b1;
                end else state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_R, C_IMM:       state_d = S_WB;
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    C_BR, C_J, C_JAL: begin
                        retire  = 1'b1;
                        state_d = S_IFETCH;
                    end
                    default:          state_d = S_HALT;
                endcase
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_IFETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
        if (state_d != state_q && (state_d == S_IFETCH || state_d == S_MEM))
            wait_d = '0;
    end

    // Moore strobes are registered from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_RST;
            cls_q        <= C_NONE;
            wait_q       <= '0;
            retired_q    <= '0;
            ill_q        <= 1'b0;
            berr_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_sel_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halted_q     <= 1'b0;
            pc_src_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            wait_q       <= wait_d;
            ill_q        <= ill_d;
            berr_q       <= berr_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            mem_req_q    <= (state_d == S_IFETCH) || (state_d == S_MEM);
            mem_we_q     <= (state_d == S_MEM) && (cls_d == C_STORE);
            addr_sel_q   <= (state_d == S_MEM);
            reg_write_q  <= (state_d == S_WB) || (state_d == S_EXEC && cls_d == C_JAL);
            mem_to_reg_q <= (state_d == S_WB) && (cls_d == C_LOAD);
            halted_q     <= (state_d == S_HALT);
            if (state_d == S_EXEC && cls_d == C_BR)                      pc_src_q <= 2'd1;
            else if (state_d == S_EXEC && (cls_d == C_J || cls_d == C_JAL)) pc_src_q <= 2'd2;
            else                                                         pc_src_q <= 2'd0;
        end
    end

    assign ir_write   = (state_q == S_IFETCH) && mem_ready;
    assign pc_write   = ((state_q == S_IFETCH) && mem_ready) ||
                        ((state_q == S_EXEC) && ((cls_q == C_BR && branch_taken) ||
                                                 cls_q == C_J || cls_q == C_JAL));
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign addr_sel   = addr_sel_q;
    assign pc_src     = pc_src_q;
    assign reg_write  = reg_write_q;
    assign mem_to_reg = mem_to_reg_q;
    assign halted     = halted_q;
    assign illegal_op = ill_q;
    assign bus_err    = berr_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: per-cycle stimulus and expected outputs are queued per instruction, then replayed and checked.
module tb_multicycle_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic [5:0]    opcode = '0, func = '0;
    logic          branch_taken = 1'b0, mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic          reg_write, mem_to_reg, halted, illegal_op, bus_err;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
        .illegal_op(illegal_op), .bus_err(bus_err), .retired(retired)
    );

    typedef struct packed {
        logic          rdy;
        logic          bt;
        logic [5:0]    op;
        logic [5:0]    fn;
        logic [11:0]   exp;
        logic [CW-1:0] ret;
    } cyc_t;

    cyc_t          sb[$];
    int            n_chk = 0, n_fail = 0;
    logic [CW-1:0] m_ret = '0;
    logic [5:0]    cur_op, cur_fn;
    logic          cur_bt;

    wire [11:0] outs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                        reg_write, mem_to_reg, halted, illegal_op, bus_err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] ov(input logic req, we, as, irw, pcw, input logic [1:0] src,
                                       input logic rw, m2r, h, ill, be);
        return {req, we, as, irw, pcw, src, rw, m2r, h, ill, be};
    endfunction

    // 0 R, 1 IMM, 2 LOAD, 3 STORE, 4 BR, 5 J, 6 JAL, 7 SYSCALL, 8 illegal
    function automatic int tb_class(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b001100) ? 7 : 0;
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111: return 1;
            6'b100011, 6'b100000: return 2;
            6'b101011, 6'b101000: return 3;
            6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: return 4;
            6'b000010: return 5;
            6'b000011: return 6;
            default: return 8;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic [11:0] exp, input logic ret_now);
        cyc_t c;
        c.rdy = rdy; c.bt = cur_bt; c.op = cur_op; c.fn = cur_fn; c.exp = exp; c.ret = m_ret;
        sb.push_back(c);
        if (ret_now) m_ret = m_ret + 1'b1;
    endtask

    task automatic push_halt(input int n, input logic ill, input logic be);
        for (int i = 0; i < n; i++) push(logic'(i % 2), ov(0,0,0,0,0,2'd0,0,0,1,ill,be), 1'b0);
    endtask

    // fw/mw: wait cycles before mem_ready in IFETCH/MEM; cut stops inside MEM without completing.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic bt,
                              input int fw, input int mw, input logic cut);
        int k;
        cur_op = op; cur_fn = fn; cur_bt = bt;
        k = tb_class(op, fn);
        for (int i = 0; i < fw; i++) push(1'b0, ov(1,0,0,0,0,2'd0,0,0,0,0,0), 1'b0);
        push(1'b1, ov(1,0,0,1,1,2'd0,0,0,0,0,0), 1'b0);
        push(1'b1, ov(0,0,0,0,0,2'd0,0,0,0,0,0), 1'b0);
        if (k == 7) begin push_halt(3, 1'b0, 1'b0); return; end
        if (k == 8) begin push_halt(3, 1'b1, 1'b0); return; end
        case (k)
            4:       push(1'b1, ov(0,0,0,0,bt,2'd1,0,0,0,0,0), 1'b1);
            5:       push(1'b1, ov(0,0,0,0,1,2'd2,0,0,0,0,0), 1'b1);
            6:       push(1'b1, ov(0,0,0,0,1,2'd2,1,0,0,0,0), 1'b1);
            default: push(1'b1, ov(0,0,0,0,0,2'd0,0,0,0,0,0), 1'b0);
        endcase
        if (k == 2 || k == 3) begin
            for (int i = 0; i < mw; i++) push(1'b0, ov(1,k==3,1,0,0,2'd0,0,0,0,0,0), 1'b0);
            if (cut) return;
            push(1'b1, ov(1,k==3,1,0,0,2'd0,0,0,0,0,0), k == 3);
        end
        if (k <= 2) push(1'b1, ov(0,0,0,0,0,2'd0,1,k==2,0,0,0), 1'b1);
    endtask

    task automatic run();
        cyc_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            mem_ready = c.rdy; branch_taken = c.bt; opcode = c.op; func = c.fn;
            #1;
            chk("outputs", {20'd0, outs}, {20'd0, c.exp});
            chk("retired", {30'd0, retired}, {30'd0, c.ret});
        end
    endtask

    // Asserts reset wherever the caller is in the cycle, then releases on the next falling edge.
    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        chk("reset_outputs", {20'd0, outs}, 32'd0);
        chk("reset_retired", {30'd0, retired}, 32'd0);
        m_ret = '0;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("rst_state_outputs", {20'd0, outs}, 32'd0);
    endtask

    initial begin
        cur_op = '0; cur_fn = '0; cur_bt = 1'b0;
        #2;
        // ADD
        do_reset();
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
        run();
        // LW with three data-wait cycles, ready lands on the last tolerated cycle
        do_reset();
        push_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);
        run();
        // BEQ not taken, then taken
        do_reset();
        push_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0);
        push_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);
        run();
        // retired instruction then SYSCALL; illegal opcode after a fresh reset
        do_reset();
        push_instr(6'b001101, 6'b000000, 1'b0, 1, 0, 1'b0);
        push_instr(6'b000000, 6'b001100, 1'b0, 0, 0, 1'b0);
        run();
        do_reset();
        push_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
        run();
        // IFETCH timeout, then ready on the final tolerated cycle
        do_reset();
        cur_op = '0; cur_fn = 6'b100000;
        for (int i = 0; i < TMO; i++) push(1'b0, ov(1,0,0,0,0,2'd0,0,0,0,0,0), 1'b0);
        push_halt(3, 1'b0, 1'b1);
        run();
        do_reset();
        push_instr(6'b000000, 6'b100000, 1'b0, TMO - 1, 0, 1'b0);
        run();
        // reset asserted mid-way through a stalled SW data access
        do_reset();
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
        push_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1);
        run();
        @(posedge clk);
        #2;
        chk("mem_req_before_reset", {31'd0, mem_req}, 32'd1);
        do_reset();
        // five retiring instructions on a 2-bit counter wrap to 1
        push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
        push_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0);
        push_instr(6'b101000, 6'b000000, 1'b0, 2, 1, 1'b0);
        push_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);
        push_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0);
        run();
        @(negedge clk);
        #1;
        chk("retired_wrap", {30'd0, retired}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
